// File: rtl/stage_mem_pkg.sv
// stage_mem_pkg: shared types, FSM states and access-size codes for the MEM stage.
package stage_mem_pkg;
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;
  typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, DRAIN} mem_state_e;
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic rd_en;
  } ctrl_sign;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } pipe_common;
  typedef struct packed {
    logic [63:0] result;
    logic [63:0] rs2;
  } exe2mem;
  typedef struct packed {
    pipe_common  pipe;
    logic        rd_en;
    logic        mem_read;
    logic [63:0] result;
    logic [63:0] readdata;
  } mem2wb;
  typedef struct packed {
    logic        rd_en;
    logic [63:0] value;
  } mem2exe_fw;
endpackage

// File: rtl/stage_mem_align.sv
// mem_align: store byte-lane placement and load extract/extend for a doubleword bus.
module mem_align
  import stage_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [2:0]  addr_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  wstrb_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o
);
  logic [7:0]  mask;
  logic [63:0] sh;
  logic        sx;
  assign mask    = size_i == MEM_B ? 8'h01 : size_i == MEM_H ? 8'h03 : size_i == MEM_W ? 8'h0f : 8'hff;
  assign wstrb_o = mask << addr_i;
  assign wdata_o = wdata_i << {addr_i, 3'b000};
  assign sh      = rdata_i >> {addr_i, 3'b000};
  assign sx      = ~uns_i;
  assign rdata_o = size_i == MEM_B ? {{56{sx & sh[7]}}, sh[7:0]} :
                   size_i == MEM_H ? {{48{sx & sh[15]}}, sh[15:0]} :
                   size_i == MEM_W ? {{32{sx & sh[31]}}, sh[31:0]} : sh;
endmodule

// File: rtl/stage_mem.sv
// stage_mem: MEM pipeline stage; runs one data-bus transaction per load/store and
// stalls the pipeline until its response arrives.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_flush,
  input  logic              mem_valid,
  input  logic              mem_advance,
  output logic              mem_ready,
  input  ctrl_sign          mem_ctrl,
  input  pipe_common        mem_pipe,
  input  exe2mem            mem_in,
  output mem2wb             mem_out,
  output mem2exe_fw         mem_exe_fw,
  output logic              mem_misalign,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [7:0]        dbus_wstrb,
  output logic [63:0]       dbus_wdata,
  input  logic              dbus_gnt,
  input  logic              dbus_rvalid,
  input  logic [63:0]       dbus_rdata
);
  mem_state_e        state_q, state_d;
  logic              killed_q, killed_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_s;
  logic [2:0]        f3_q, f3_s;
  logic [63:0]       rs2_q, rs2_s;
  logic              we_q, we_s;
  logic              idle, access, mis, memop, issue;
  logic [1:0]        size;
  logic [2:0]        alo;
  logic [7:0]        lane_strb;
  logic [63:0]       lane_wdata, load_data, readdata;
  assign idle   = state_q == IDLE;
  assign size   = mem_pipe.instr[13:12];
  assign alo    = mem_in.result[2:0];
  assign access = mem_valid & (mem_ctrl.mem_read | mem_ctrl.mem_write);
  assign mis    = CHECK_ALIGN & ((size == MEM_H & alo[0]) | (size == MEM_W & |alo[1:0]) | (size == MEM_D & |alo));
  assign mem_misalign = access & mis;
  assign memop  = access & ~mis;
  assign issue  = idle & memop & ~mem_flush;
  // Request fields track the pipeline while idle and freeze once a transaction is in flight.
  assign addr_s = idle ? mem_in.result[ADDR_W-1:0] : addr_q;
  assign f3_s   = idle ? mem_pipe.instr[14:12] : f3_q;
  assign rs2_s  = idle ? mem_in.rs2 : rs2_q;
  assign we_s   = idle ? mem_ctrl.mem_write : we_q;
  mem_align u_align (
    .size_i (f3_s[1:0]),
    .uns_i  (f3_s[2]),
    .addr_i (addr_s[2:0]),
    .wdata_i(rs2_s),
    .rdata_i(dbus_rdata),
    .wstrb_o(lane_strb),
    .wdata_o(lane_wdata),
    .rdata_o(load_data)
  );
  assign dbus_req   = ~rst & (issue | state_q == REQ);
  assign dbus_we    = dbus_req & we_s;
  assign dbus_wstrb = dbus_we ? lane_strb : 8'h00;
  assign dbus_wdata = lane_wdata;
  assign dbus_addr  = {addr_s[ADDR_W-1:3], 3'b000};
  assign mem_ready  = idle ? (~memop | mem_flush) : state_q == RESP ? dbus_rvalid : state_q == DONE;
  assign readdata   = state_q == DONE ? rdata_q : (state_q == RESP & dbus_rvalid) ? load_data : 64'h0;
  assign mem_out    = '{pipe: mem_pipe, rd_en: mem_ctrl.rd_en, mem_read: mem_ctrl.mem_read,
                        result: mem_in.result, readdata: readdata};
  assign mem_exe_fw = '{rd_en: mem_ctrl.rd_en, value: mem_ctrl.mem_read ? readdata : mem_in.result};
  always_comb begin
    state_d  = state_q;
    killed_d = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE:  if (issue) state_d = dbus_gnt ? RESP : REQ;
      REQ: begin
        killed_d = killed_q | mem_flush;
        if (dbus_gnt) state_d = killed_d ? DRAIN : RESP;
      end
      RESP:
        if (dbus_rvalid) begin
          rdata_d = load_data;
          state_d = (mem_flush | mem_advance) ? IDLE : DONE;
        end else if (mem_flush) state_d = DRAIN;
      DONE:  if (mem_advance | mem_flush) state_d = IDLE;
      DRAIN: if (dbus_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      killed_q <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      f3_q     <= '0;
      rs2_q    <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      killed_q <= killed_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_s;
      f3_q     <= f3_s;
      rs2_q    <= rs2_s;
      we_q     <= we_s;
    end
  end
endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: directed load/store/stall/flush/misalign/reset checks with a readdata scoreboard.
module tb_stage_mem;
  import stage_mem_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush, valid, advance, ready, misalign;
  ctrl_sign    ctrl;
  pipe_common  pipe;
  exe2mem      ein;
  mem2wb       mout;
  mem2exe_fw   fw;
  logic        req, we, gnt, rvalid;
  logic [63:0] addr, wdata, rdata;
  logic [7:0]  strb;
  logic [63:0] sb[$];
  int          n_chk = 0;
  int          n_fail = 0;

  stage_mem #(.ADDR_W(64), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst), .mem_flush(flush), .mem_valid(valid), .mem_advance(advance),
    .mem_ready(ready), .mem_ctrl(ctrl), .mem_pipe(pipe), .mem_in(ein), .mem_out(mout),
    .mem_exe_fw(fw), .mem_misalign(misalign), .dbus_req(req), .dbus_we(we),
    .dbus_addr(addr), .dbus_wstrb(strb), .dbus_wdata(wdata), .dbus_gnt(gnt),
    .dbus_rvalid(rvalid), .dbus_rdata(rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [63:0] e;
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    chk(tag, mout.readdata, e);
  endtask

  task automatic op(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
    valid = 1'b1;
    ctrl  = '{mem_read: rd, mem_write: wr, rd_en: rd};
    pipe  = '{pc: 64'h100, instr: {17'b0, f3, 12'b0}};
    ein   = '{result: a, rs2: d};
  endtask

  initial begin
    flush = 0; valid = 0; advance = 0; gnt = 0; rvalid = 0; rdata = '0;
    ctrl = '0; pipe = '0; ein = '0;
    cyc(); cyc();
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_wstrb", 64'(strb), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    rst = 0;
    cyc();
    // LB 0x1003: byte 0x80 sign-extends
    op(1, 0, 3'b000, 64'h1003, 0); gnt = 1; sb.push_back(64'hFFFF_FFFF_FFFF_FF80);
    #1 chk("lb_req", 64'(req), 64'd1);
    chk("lb_addr", addr, 64'h1000);
    chk("lb_we", 64'(we), 64'd0);
    chk("lb_stall", 64'(ready), 64'd0);
    cyc();
    gnt = 0; rvalid = 1; rdata = 64'h0000_0000_8000_0000; advance = 1;
    #1 chk("lb_ready", 64'(ready), 64'd1);
    pop_chk("lb_data");
    chk("lb_fw", fw.value, 64'hFFFF_FFFF_FFFF_FF80);
    cyc();
    // LBU 0x1003, held in DONE for a cycle
    op(1, 0, 3'b100, 64'h1003, 0); rvalid = 0; advance = 0; gnt = 1; sb.push_back(64'h80);
    #1 chk("lbu_stall", 64'(ready), 64'd0);
    cyc();
    gnt = 0; rvalid = 1;
    #1 chk("lbu_ready", 64'(ready), 64'd1);
    chk("lbu_rv_data", mout.readdata, 64'h80);
    cyc();
    rvalid = 0;
    #1 chk("lbu_done_ready", 64'(ready), 64'd1);
    pop_chk("lbu_done_data");
    advance = 1;
    cyc();
    // SH 0x2006
    advance = 0; op(0, 1, 3'b001, 64'h2006, 64'hABCD); gnt = 1;
    #1 chk("sh_wstrb", 64'(strb), 64'hC0);
    chk("sh_wdata", wdata, 64'hABCD_0000_0000_0000);
    chk("sh_addr", addr, 64'h2000);
    chk("sh_we", 64'(we), 64'd1);
    chk("sh_stall", 64'(ready), 64'd0);
    cyc();
    gnt = 0; rvalid = 1; advance = 1;
    #1 chk("sh_ack_ready", 64'(ready), 64'd1);
    cyc();
    // LD 0x4008 with grant withheld 3 cycles
    rvalid = 0; advance = 0; op(1, 0, 3'b011, 64'h4008, 64'h1122); gnt = 0;
    sb.push_back(64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_req", 64'(req), 64'd1);
      chk("stall_addr", addr, 64'h4008);
      chk("stall_wdata", wdata, 64'h1122);
      chk("stall_ready", 64'(ready), 64'd0);
      cyc();
    end
    gnt = 1;
    #1 chk("stall_gnt_ready", 64'(ready), 64'd0);
    cyc();
    gnt = 0; rvalid = 1; rdata = 64'h0123_4567_89AB_CDEF; advance = 1;
    #1 chk("ld_ready", 64'(ready), 64'd1);
    pop_chk("ld_data");
    cyc();
    // LW 0x5004 flushed while waiting for grant
    rvalid = 0; advance = 0; op(1, 0, 3'b010, 64'h5004, 0); gnt = 0;
    #1 chk("fl_req0", 64'(req), 64'd1);
    cyc();
    flush = 1;
    #1 chk("fl_req1", 64'(req), 64'd1);
    chk("fl_ready1", 64'(ready), 64'd0);
    cyc();
    flush = 0; valid = 0; gnt = 1;
    #1 chk("fl_req2", 64'(req), 64'd1);
    chk("fl_addr2", addr, 64'h5000);
    chk("fl_ready2", 64'(ready), 64'd0);
    cyc();
    gnt = 0;
    #1 chk("drain_ready", 64'(ready), 64'd0);
    chk("drain_req", 64'(req), 64'd0);
    cyc();
    rvalid = 1; rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    #1 chk("drain_rv_ready", 64'(ready), 64'd0);
    chk("drain_rv_data", mout.readdata, 64'h0);
    cyc();
    rvalid = 0;
    #1 chk("drain_exit_ready", 64'(ready), 64'd1);
    chk("drain_exit_req", 64'(req), 64'd0);
    // misaligned accesses issue nothing
    op(1, 0, 3'b010, 64'h3002, 0);
    #1 chk("lw_mis", 64'(misalign), 64'd1);
    chk("lw_mis_req", 64'(req), 64'd0);
    chk("lw_mis_ready", 64'(ready), 64'd1);
    cyc();
    op(0, 1, 3'b011, 64'h3004, 64'h55);
    #1 chk("sd_mis", 64'(misalign), 64'd1);
    chk("sd_mis_req", 64'(req), 64'd0);
    chk("sd_mis_wstrb", 64'(strb), 64'd0);
    cyc();
    // async reset while awaiting response
    op(1, 0, 3'b000, 64'h1000, 0); gnt = 1;
    cyc();
    gnt = 0;
    #2 rst = 1;
    #1 chk("rst_resp_req", 64'(req), 64'd0);
    valid = 0;
    #1 chk("rst_resp_ready", 64'(ready), 64'd1);
    cyc();
    rst = 0;
    cyc();
    // LB 0x1001: positive byte 0x7F after reset
    op(1, 0, 3'b000, 64'h1001, 0); gnt = 1; sb.push_back(64'h7F);
    #1 chk("post_rst_req", 64'(req), 64'd1);
    cyc();
    gnt = 0; rvalid = 1; rdata = 64'h0000_0000_0000_7F00; advance = 1;
    #1 chk("post_rst_ready", 64'(ready), 64'd1);
    pop_chk("post_rst_data");
    cyc();
    rvalid = 0; advance = 0; valid = 0;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
